stage_mem: RTL and testbench

//  Memory stage: consumer of the execute-stage result bundle (rvcpu::stage_ex_t).
//  Non-memory results pass through to writeback after one register.
//  For memory ops: drives a valid/ready data-bus request from out.addr/out.data,

---
 rtl/stage_mem_pkg.sv | 61 ++++++
 rtl/stage_mem_load_align.sv | 27 ++
 rtl/stage_mem.sv | 143 ++++++++++++++
 tb/tb_stage_mem.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared types and store-lane helpers for the memory stage.
// The execute-stage bundle is consumed as-is; the memory-stage bundle is registered for writeback.
package stage_mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    mem_b = 2'b00,
    mem_h = 2'b01,
    mem_w = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            rd_valid;
    logic            is_mem;
    logic [3:0]      op;
    logic [XLEN-1:0] addr;
  } stage_ex_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            rd_valid;
    logic [XLEN-1:0] data;
    logic            misaligned;
  } stage_mem_t;

  function automatic logic [3:0] store_strb(input mem_size_t size, input logic [1:0] offset);
    case (size)
      mem_b:   store_strb = 4'b0001 << offset;
      mem_h:   store_strb = 4'b0011 << offset;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input mem_size_t size, input logic [XLEN-1:0] d);
    case (size)
      mem_b:   store_data = {4{d[7:0]}};
      mem_h:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
    case (size)
      mem_b:   is_misaligned = 1'b0;
      mem_h:   is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/stage_mem_load_align.sv
// Load-data alignment: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it to the full register width.
module stage_mem_load_align
  import stage_mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  mem_size_t       size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension on the selected element's top bit.
  always_comb begin
    byte_s = rdata[8*offset +: 8];
    half_s = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      mem_b:   data = {{24{~is_unsigned & byte_s[7]}}, byte_s};
      mem_h:   data = {{16{~is_unsigned & half_s[15]}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory stage: passes non-memory results to writeback after one register and
// runs loads/stores over a valid/ready data bus, stalling execute meanwhile.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  stage_ex_t        in,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [Width-1:0] mem_addr,
  output logic             mem_we,
  output logic [3:0]       mem_wstrb,
  output logic [Width-1:0] mem_wdata,
  input  logic             mem_rsp_valid,
  input  logic [Width-1:0] mem_rdata,
  output stage_mem_t       out
);

  mem_state_t      state_r, state_s;
  stage_mem_t      out_r, out_s;
  logic            latch_s;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] data_r;
  logic [3:0]      op_r;
  logic [4:0]      rd_r;
  logic            rd_valid_r;
  logic [XLEN-1:0] load_data_s;
  mem_size_t       size_r_s;
  mem_size_t       size_in_s;

  assign size_r_s  = mem_size_t'(op_r[1:0]);
  assign size_in_s = mem_size_t'(in.op[1:0]);

  // Bus fields come straight from the latched request so they stay stable while REQ waits.
  assign in_ready      = (state_r == IDLE);
  assign mem_req_valid = (state_r == REQ);
  assign mem_we        = (state_r == REQ) & op_r[3];
  assign mem_wstrb     = ((state_r == REQ) && op_r[3]) ? store_strb(size_r_s, addr_r[1:0]) : 4'b0000;
  assign mem_addr      = {addr_r[31:2], 2'b00};
  assign mem_wdata     = store_data(size_r_s, data_r);
  assign out           = out_r;

  stage_mem_load_align u_load_align (
    .rdata       (mem_rdata),
    .offset      (addr_r[1:0]),
    .size        (size_r_s),
    .is_unsigned (op_r[2]),
    .data        (load_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next writeback bundle; valid defaults low so it only ever pulses.
  always_comb begin
    state_s   = state_r;
    out_s     = out_r;
    out_s.valid = 1'b0;
    latch_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && !in.is_mem) begin
          out_s.valid      = 1'b1;
          out_s.data       = in.data;
          out_s.rd         = in.rd;
          out_s.rd_valid   = in.rd_valid;
          out_s.misaligned = 1'b0;
        end else if (in_valid && is_misaligned(size_in_s, in.addr[1:0])) begin
          out_s.valid      = 1'b1;
          out_s.rd         = in.rd;
          out_s.rd_valid   = 1'b0;
          out_s.misaligned = 1'b1;
        end else if (in_valid) begin
          latch_s = 1'b1;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready && op_r[3]) begin
          out_s.valid      = 1'b1;
          out_s.rd         = rd_r;
          out_s.rd_valid   = 1'b0;
          out_s.misaligned = 1'b0;
          state_s          = IDLE;
        end else if (mem_req_ready) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          out_s.valid      = 1'b1;
          out_s.rd         = rd_r;
          out_s.rd_valid   = rd_valid_r;
          out_s.data       = load_data_s;
          out_s.misaligned = 1'b0;
          state_s          = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Writeback register and request latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r      <= '0;
      addr_r     <= 32'h0000_0000;
      data_r     <= 32'h0000_0000;
      op_r       <= 4'b0000;
      rd_r       <= 5'd0;
      rd_valid_r <= 1'b0;
    end else begin
      out_r <= out_s;
      if (latch_s) begin
        addr_r     <= in.addr;
        data_r     <= in.data;
        op_r       <= in.op;
        rd_r       <= in.rd;
        rd_valid_r <= in.rd_valid;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed corner cases plus randomized
// transactions checked against a byte-level behavioural model.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  stage_ex_t   ex_s = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0000_0000;
  stage_mem_t  out_s;

  int n_checks = 0;
  int n_errors = 0;

  stage_mem #(.Width(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in            (ex_s),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .out           (out_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; expected values come from byte-level arithmetic.
  task automatic run_txn(input logic is_mem, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd, input logic rd_valid,
                         input int ready_dly, input int rsp_dly, input logic [31:0] rdata);
    int          nbytes;
    logic [1:0]  off;
    logic        mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] mask;
    logic [31:0] val;
    off    = addr[1:0];
    nbytes = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    mis    = is_mem && ((addr % nbytes) != 0);
    exp_strb = 4'(((1 << nbytes) - 1) << ((nbytes == 4) ? 0 : off));
    for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = data[8*(i % nbytes) +: 8];
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nbytes)) - 32'd1);
    val  = (rdata >> (8*off)) & mask;
    if (!op[2] && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;

    check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
    ex_s.data = data; ex_s.rd = rd; ex_s.rd_valid = rd_valid;
    ex_s.is_mem = is_mem; ex_s.op = op; ex_s.addr = addr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ex_s.data = $urandom; ex_s.addr = $urandom; ex_s.op = 4'($urandom); ex_s.rd = 5'($urandom);

    if (!is_mem || mis) begin
      check_eq("out_valid", {31'd0, out_s.valid}, 32'd1);
      check_eq("misaligned", {31'd0, out_s.misaligned}, {31'd0, mis});
      check_eq("req_none", {31'd0, mem_req_valid}, 32'd0);
      if (!mis) begin
        check_eq("pass_data", out_s.data, data);
        check_eq("pass_rd", {27'd0, out_s.rd}, {27'd0, rd});
        check_eq("pass_rdv", {31'd0, out_s.rd_valid}, {31'd0, rd_valid});
      end else begin
        check_eq("mis_rdv", {31'd0, out_s.rd_valid}, 32'd0);
      end
    end else begin
      for (int k = 0; k <= ready_dly; k++) begin
        check_eq("req_valid", {31'd0, mem_req_valid}, 32'd1);
        check_eq("req_addr", mem_addr, {addr[31:2], 2'b00});
        check_eq("req_we", {31'd0, mem_we}, {31'd0, op[3]});
        check_eq("req_strb", {28'd0, mem_wstrb}, op[3] ? {28'd0, exp_strb} : 32'd0);
        if (op[3]) check_eq("req_wdata", mem_wdata, exp_wdata);
        check_eq("stall", {31'd0, in_ready}, 32'd0);
        check_eq("out_quiet", {31'd0, out_s.valid}, 32'd0);
        mem_req_ready = (k == ready_dly);
        tick();
      end
      mem_req_ready = 1'b0;
      if (op[3]) begin
        check_eq("st_valid", {31'd0, out_s.valid}, 32'd1);
        check_eq("st_rdv", {31'd0, out_s.rd_valid}, 32'd0);
        check_eq("st_req_off", {31'd0, mem_req_valid}, 32'd0);
      end else begin
        for (int k = 0; k < rsp_dly; k++) begin
          check_eq("wait_req_off", {31'd0, mem_req_valid}, 32'd0);
          check_eq("wait_stall", {31'd0, in_ready}, 32'd0);
          check_eq("wait_quiet", {31'd0, out_s.valid}, 32'd0);
          tick();
        end
        mem_rsp_valid = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata = $urandom;
        check_eq("ld_valid", {31'd0, out_s.valid}, 32'd1);
        check_eq("ld_data", out_s.data, val);
        check_eq("ld_rd", {27'd0, out_s.rd}, {27'd0, rd});
        check_eq("ld_rdv", {31'd0, out_s.rd_valid}, {31'd0, rd_valid});
        check_eq("ld_mis", {31'd0, out_s.misaligned}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    #2;
    check_eq("rst_out_valid", {31'd0, out_s.valid}, 32'd0);
    check_eq("rst_out_data", out_s.data, 32'd0);
    check_eq("rst_out_rd", {27'd0, out_s.rd}, 32'd0);
    check_eq("rst_out_rdv", {31'd0, out_s.rd_valid}, 32'd0);
    check_eq("rst_out_mis", {31'd0, out_s.misaligned}, 32'd0);
    check_eq("rst_req", {31'd0, mem_req_valid}, 32'd0);
    check_eq("rst_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_strb", {28'd0, mem_wstrb}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #10 rst = 1'b1;
    tick();

    run_txn(1'b0, 4'b0000, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 0, 0, 32'h0);
    run_txn(1'b1, 4'b1010, 32'h100, 32'hDEAD_BEEF, 5'd7, 1'b1, 0, 0, 32'h0);
    run_txn(1'b1, 4'b1000, 32'h103, 32'h0000_00AB, 5'd7, 1'b1, 3, 0, 32'h0);
    run_txn(1'b1, 4'b0000, 32'h101, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0000_8000);
    run_txn(1'b1, 4'b0100, 32'h101, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0000_8000);
    run_txn(1'b1, 4'b0001, 32'h102, 32'h0, 5'd10, 1'b1, 0, 0, 32'h8001_0000);
    run_txn(1'b1, 4'b0010, 32'h102, 32'h0, 5'd11, 1'b1, 0, 0, 32'h0);

    // Reset while a load sits in WAIT; a late response must be ignored.
    ex_s.is_mem = 1'b1; ex_s.op = 4'b0010; ex_s.addr = 32'h200; ex_s.rd = 5'd3; ex_s.rd_valid = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check_eq("wait_entered", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("arst_req", {31'd0, mem_req_valid}, 32'd0);
    check_eq("arst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("late_rsp_ignored", {31'd0, out_s.valid}, 32'd0);
    check_eq("late_rsp_idle", {31'd0, in_ready}, 32'd1);

    // Reset while the request is still pending drops it at once.
    ex_s.op = 4'b1010; ex_s.addr = 32'h300;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("req_pending", {31'd0, mem_req_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("arst_req_drop", {31'd0, mem_req_valid}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom);
      op[1:0] = 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = (op[1:0] == 2'b10) ? 2'b00 : {addr[1], 1'b0};
      if ($urandom_range(0, 2) == 0) begin
        mem_rsp_valid = $urandom_range(0, 1) == 1;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("gap_quiet", {31'd0, out_s.valid}, 32'd0);
      end
      run_txn($urandom_range(0, 3) != 0, op, addr, $urandom, 5'($urandom), 1'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    tick();
    check_eq("final_quiet", {31'd0, out_s.valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
